hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 217 +++++++++++++++++++++
 tb/tb_hazard_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller for a five-stage in-order core.
//   - Forwarding select for both execute-stage ALU operands (memory stage has
//     priority over writeback; register x0 is never forwarded).
//   - Load-use stall detection between execute and decode.
//   - Data-memory wait handling: a small IDLE/WAIT/TIMEOUT machine stalls the
//     pipeline while the data memory is busy, and latches a sticky timeout
//     once TIMEOUT_LIMIT consecutive wait cycles have elapsed.
//   - Saturating 16-bit counter of stalled fetch cycles.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   Rs1D, Rs2D                    decode-stage source registers
//   Rs1E, Rs2E, RdE               execute-stage source / destination registers
//   RdM, RdW                      memory / writeback destination registers
//   RegWriteM, RegWriteW          register-write enables (memory, writeback)
//   ResultSrcE                    execute result select, 2'b01 = load
//   PCSrcE                        taken branch or jump
//   MemAccessM                    memory stage holds a load or store
//   DMemReady                     data memory completed the access this cycle
//   StallF/D/E/M                  hold the corresponding pipeline register
//   FlushD/E/W                    bubble the corresponding pipeline register
//   ForwardAE, ForwardBE          operand select: 00 RF, 01 WB, 10 MEM
//   MemTimeout                    sticky data-memory timeout flag
//   StallCnt                      saturating count of stalled fetch cycles
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned TIMEOUT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MemAccessM,
  input  logic        DMemReady,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemTimeout,
  output logic [15:0] StallCnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT    = 2'b01,
    S_TIMEOUT = 2'b10
  } state_t;

  // Last wait count before the machine gives up on the data memory.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_LIMIT - 32'd1);

  // Forward from the youngest in-flight writer; x0 is hard-wired zero.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_cnt_nxt_s;
  logic        mem_stall_s;
  logic        lw_stall_s;
  logic        mem_timeout_r;
  logic [15:0] stall_cnt_r;

  // Load-use detection: a load in execute feeds a source read in decode.
  always_comb begin
    lw_stall_s = 1'b0;
    if ((ResultSrcE == 2'b01) && (RdE != 5'd0) &&
        ((RdE == Rs1D) || (RdE == Rs2D))) begin
      lw_stall_s = 1'b1;
    end else begin
      lw_stall_s = 1'b0;
    end
  end

  // Memory-wait machine: next state, next wait count and the memory stall.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    mem_stall_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (MemAccessM && !DMemReady) begin
          mem_stall_s    = 1'b1;
          state_nxt_s    = S_WAIT;
          wait_cnt_nxt_s = 8'd1;
        end else begin
          wait_cnt_nxt_s = 8'd0;
        end
      end
      S_WAIT: begin
        if (DMemReady) begin
          state_nxt_s    = S_IDLE;
          wait_cnt_nxt_s = 8'd0;
        end else begin
          mem_stall_s = 1'b1;
          if (wait_cnt_r == WAIT_LAST) begin
            state_nxt_s = S_TIMEOUT;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
          end
        end
      end
      S_TIMEOUT: begin
        // Absorbing: the memory is considered dead until reset.
        mem_stall_s = 1'b1;
      end
      default: begin
        state_nxt_s    = S_IDLE;
        wait_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Sticky timeout flag, raised on entry to TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_timeout_r <= 1'b0;
    end else if (state_nxt_s == S_TIMEOUT) begin
      mem_timeout_r <= 1'b1;
    end else begin
      mem_timeout_r <= mem_timeout_r;
    end
  end

  // Stall and flush combination; everything is forced quiet while in reset.
  // A memory stall freezes E/M, so any flush of D/E would lose instructions.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      StallF    = lw_stall_s | mem_stall_s;
      StallD    = lw_stall_s | mem_stall_s;
      StallE    = mem_stall_s;
      StallM    = mem_stall_s;
      FlushW    = mem_stall_s;
      FlushD    = PCSrcE & ~mem_stall_s;
      FlushE    = (lw_stall_s | PCSrcE) & ~mem_stall_s;
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    end else begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

  // Saturating stalled-fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (StallF && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign MemTimeout = mem_timeout_r;
  assign StallCnt   = stall_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, MemAccessM, DMemReady;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        MemTimeout;
  logic [15:0] StallCnt;
  logic [10:0] outs;

  hazard_unit #(.TIMEOUT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .DMemReady(DMemReady),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeout(MemTimeout), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: outstanding access, wait length, timeout, count.
  bit m_busy;
  bit m_to;
  int m_waited;
  int m_cnt;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww;
    logic [1:0] rsrc;
    logic       pc;
    logic [1:0] fa, fb;
    logic       st, fd, fe;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
    input logic rwm, rww, input logic [1:0] rsrc, input logic pc,
    input logic [1:0] fa, fb, input logic st, fd, fe);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rwm = rwm; v.rww = rww;
    v.rsrc = rsrc; v.pc = pc; v.fa = fa; v.fb = fb;
    v.st = st; v.fd = fd; v.fe = fe;
    return v;
  endfunction

  function automatic logic [10:0] pack(input logic [1:0] fa, fb,
                                       input logic st, ms, fd, fe);
    return {st, st, ms, ms, fd, fe, ms, fa, fb};
  endfunction

  // Forwarding rule written directly from the priority description.
  function automatic int fwd_ref(input int rs, input bit rwm, input int rdm,
                                 input bit rww, input int rdw);
    if (rwm && rdm != 0 && rdm == rs) return 2;
    if (rww && rdw != 0 && rdw == rs) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; MemAccessM = 1'b0; DMemReady = 1'b1;
  endtask

  // Pulse reset away from the clock edge and check the in-reset state.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_cnt", 32'(StallCnt), 32'd0);
    chk("reset_timeout", 32'(MemTimeout), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_busy = 1'b0; m_to = 1'b0; m_waited = 0; m_cnt = 0;
  endtask

  initial begin
    int exp_cnt;
    clear_in();
    @(posedge clk);
    #1;
    do_reset();

    // ---------------- table-driven combinational vectors ----------------
    //              rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pc  fa fb st fd fe
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[1]  = mk(0, 0, 5, 0, 0, 5, 5, 1, 1, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0);
    vecs[2]  = mk(0, 0, 5, 0, 0, 5, 5, 0, 1, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0);
    vecs[3]  = mk(0, 0, 5, 0, 0, 0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 9, 0, 3, 9, 1, 1, 2'b00, 0, 2'b00, 2'b01, 0, 0, 0);
    vecs[5]  = mk(0, 0, 4, 4, 0, 4, 2, 1, 1, 2'b00, 0, 2'b10, 2'b10, 0, 0, 0);
    vecs[6]  = mk(0, 0, 6, 0, 0, 6, 6, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[7]  = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 1);
    vecs[8]  = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[10] = mk(7, 0, 0, 0, 7, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 1, 1);
    vecs[12] = mk(0, 7, 0, 0, 7, 0, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 1, 1, 1);
    vecs[13] = mk(8, 9, 0, 0, 7, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
    vecs[14] = mk(0, 0, 3, 12, 0, 3, 12, 1, 1, 2'b00, 0, 2'b10, 2'b01, 0, 0, 0);

    exp_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      clear_in();
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e;
      Rs2E = vecs[i].rs2e; RdE = vecs[i].rde; RdM = vecs[i].rdm;
      RdW = vecs[i].rdw; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
      ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs),
          32'(pack(vecs[i].fa, vecs[i].fb, vecs[i].st, 1'b0, vecs[i].fd, vecs[i].fe)));
      @(posedge clk);
      #1;
      if (vecs[i].st) exp_cnt++;
      chk($sformatf("vec%0d_cnt", i), 32'(StallCnt), 32'(exp_cnt));
    end

    // ---------------- memory wait of three cycles ----------------
    do_reset();
    clear_in();
    MemAccessM = 1'b1; DMemReady = 1'b0; PCSrcE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("memwait_c%0d", k), 32'(outs), 32'(pack(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0)));
      @(posedge clk);
      #1;
    end
    DMemReady = 1'b1; PCSrcE = 1'b0;
    #1;
    chk("memwait_done", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    // IDLE does not stall on a not-ready memory without a fresh access.
    MemAccessM = 1'b0; DMemReady = 1'b0;
    #1;
    chk("memwait_idle", 32'(outs), 32'd0);
    chk("memwait_cnt", 32'(StallCnt), 32'd3);
    @(posedge clk);
    #1;

    // ---------------- timeout and reset recovery ----------------
    do_reset();
    clear_in();
    MemAccessM = 1'b1; DMemReady = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      #1;
      chk($sformatf("tmo_stall_c%0d", k), 32'(outs), 32'(pack(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0)));
      chk($sformatf("tmo_flag_c%0d", k), 32'(MemTimeout), (k >= 5) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    MemAccessM = 1'b0; DMemReady = 1'b1;
    #1;
    chk("tmo_absorb", 32'(outs), 32'(pack(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0)));
    chk("tmo_sticky", 32'(MemTimeout), 32'd1);
    Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    do_reset();
    clear_in();
    #1;
    chk("tmo_after_reset_outs", 32'(outs), 32'd0);
    chk("tmo_after_reset_flag", 32'(MemTimeout), 32'd0);
    @(posedge clk);
    #1;

    // ---------------- reset in the middle of a wait ----------------
    do_reset();
    clear_in();
    MemAccessM = 1'b1; DMemReady = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    MemAccessM = 1'b0; DMemReady = 1'b0;
    #1;
    chk("midwait_reset_outs", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    chk("midwait_reset_cnt", 32'(StallCnt), 32'd0);

    // ---------------- stall counter saturation ----------------
    do_reset();
    clear_in();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    for (int i = 1; i <= 65537; i++) begin
      @(posedge clk);
      #1;
      if (i == 65534) chk("sat_pre", 32'(StallCnt), 32'hFFFE);
    end
    chk("sat_cnt", 32'(StallCnt), 32'hFFFF);
    chk("sat_outs", 32'(outs), 32'(pack(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1)));

    // ---------------- randomized against reference model ----------------
    do_reset();
    clear_in();
    for (int n = 0; n < 1500; n++) begin
      bit lw, ms, st, fd, fe;
      int fa, fb;
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3)); PCSrcE = 1'($urandom_range(0, 1));
      MemAccessM = 1'($urandom_range(0, 1));
      DMemReady = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
      #1;
      lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
      ms = m_to || (!DMemReady && (m_busy || MemAccessM));
      st = lw || ms;
      fd = PCSrcE && !ms;
      fe = (lw || PCSrcE) && !ms;
      fa = fwd_ref(int'(Rs1E), RegWriteM, int'(RdM), RegWriteW, int'(RdW));
      fb = fwd_ref(int'(Rs2E), RegWriteM, int'(RdM), RegWriteW, int'(RdW));
      chk("rand_outs", 32'(outs), 32'(pack(2'(fa), 2'(fb), st, ms, fd, fe)));
      chk("rand_timeout", 32'(MemTimeout), 32'(m_to));
      chk("rand_cnt", 32'(StallCnt), 32'(m_cnt));
      @(posedge clk);
      if (st && m_cnt < 65535) m_cnt++;
      if (!m_to) begin
        if (ms) begin
          m_busy = 1'b1;
          m_waited++;
          if (m_waited >= LIMIT) m_to = 1'b1;
        end else begin
          m_busy = 1'b0;
          m_waited = 0;
        end
      end
      #1;
      if ((m_to && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
